// File: rtl/mux_8to1.sv
// 8:1 lane selector built as a three-level tree of 2:1 cells; out is combinational, out_q/out_vld one cycle later.
// No backpressure: accepts one selection every cycle; rst clears only the registered copy.
module mux_8to1 #(
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*DATA_W-1:0]   in,
  input  logic [2:0]            sel,
  input  logic                  in_vld,
  output logic [DATA_W-1:0]     out,
  output logic [DATA_W-1:0]     out_q,
  output logic                  out_vld
);

  logic [DATA_W-1:0] lvl1 [4];
  logic [DATA_W-1:0] lvl2 [2];

  // Level 1 pairs adjacent lanes on sel[0]; level 2 pairs on sel[1]; root on sel[2].
  for (genvar i = 0; i < 4; i++) begin : g_lvl1
    assign lvl1[i] = sel[0] ? in[(2*i+1)*DATA_W +: DATA_W] : in[(2*i)*DATA_W +: DATA_W];
  end

  for (genvar j = 0; j < 2; j++) begin : g_lvl2
    assign lvl2[j] = sel[1] ? lvl1[2*j+1] : lvl1[2*j];
  end

  assign out = sel[2] ? lvl2[1] : lvl2[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_q <= out;
      end
    end
  end

endmodule

// File: tb/tb_mux_8to1.sv
// Bench for mux_8to1: three widths side by side, directed sweeps, reset cases and random vectors.
module tb_mux_8to1;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic [2:0]   sel    = '0;
  logic         in_vld = 1'b0;
  logic [7:0]   in1    = '0;
  logic [63:0]  in8    = '0;
  logic [255:0] in32   = '0;

  logic         out1, q1, vld1;
  logic [7:0]   out8, q8;
  logic         vld8;
  logic [31:0]  out32, q32;
  logic         vld32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_8to1 #(.DATA_W(1)) u_w1 (
    .clk(clk), .rst(rst), .in(in1), .sel(sel), .in_vld(in_vld),
    .out(out1), .out_q(q1), .out_vld(vld1)
  );

  mux_8to1 #(.DATA_W(8)) u_w8 (
    .clk(clk), .rst(rst), .in(in8), .sel(sel), .in_vld(in_vld),
    .out(out8), .out_q(q8), .out_vld(vld8)
  );

  mux_8to1 #(.DATA_W(32)) u_w32 (
    .clk(clk), .rst(rst), .in(in32), .sel(sel), .in_vld(in_vld),
    .out(out32), .out_q(q32), .out_vld(vld32)
  );

  // Reference: lane s of a flat vector is simply a shift-and-mask.
  function automatic logic [63:0] lane_of(input logic [255:0] v, input int w, input int s);
    logic [255:0] m;
    m = (256'h1 << w) - 256'h1;
    return 64'((v >> (s * w)) & m);
  endfunction

  logic [63:0] m_q1, m_q8, m_q32;
  logic        m_vld;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q1  <= '0;
      m_q8  <= '0;
      m_q32 <= '0;
      m_vld <= 1'b0;
    end else begin
      m_vld <= in_vld;
      if (in_vld) begin
        m_q1  <= lane_of({248'b0, in1}, 1, int'(sel));
        m_q8  <= lane_of({192'b0, in8}, 8, int'(sel));
        m_q32 <= lane_of(in32, 32, int'(sel));
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step_capture(input logic [2:0] s, input logic v);
    @(negedge clk);
    sel    = s;
    in_vld = v;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pat;

  initial begin
    // Reset state, and clock edges ignored while rst is high.
    #1;
    check("rst_q8", 64'(q8), 64'h0);
    check("rst_vld8", 64'(vld8), 64'h0);
    check("rst_q32", 64'(q32), 64'h0);
    for (int k = 0; k < 8; k++) in8[k*8 +: 8] = 8'(8'hA0 + k);
    sel    = 3'd3;
    in_vld = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_q8", 64'(q8), 64'h0);
    check("rst_hold_vld8", 64'(vld8), 64'h0);
    check("rst_live_out8", 64'(out8), 64'hA3);
    @(negedge clk);
    rst    = 1'b0;
    in_vld = 1'b0;

    // Width-1 sweeps with a 10-unit hold per select value.
    pat = 8'b10101010;
    in1 = pat;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      check("sweep_aa", 64'(out1), 64'(pat[s]));
      #9;
    end
    pat = 8'b11110000;
    in1 = pat;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      check("sweep_f0", 64'(out1), 64'(s >= 4 ? 1 : 0));
      #9;
    end

    // Registered sweep, one select per clock.
    for (int k = 0; k < 8; k++) begin
      step_capture(3'(k), 1'b1);
      check("reg_sweep_q", 64'(q8), 64'(8'hA0 + k));
      check("reg_sweep_vld", 64'(vld8), 64'h1);
    end

    // Two idle cycles mid-sweep hold the last captured lane.
    for (int k = 0; k < 3; k++) step_capture(3'(k), 1'b1);
    check("pre_idle_q", 64'(q8), 64'hA2);
    for (int k = 3; k < 5; k++) begin
      step_capture(3'(k), 1'b0);
      check("idle_q_hold", 64'(q8), 64'hA2);
      check("idle_vld", 64'(vld8), 64'h0);
    end
    step_capture(3'd5, 1'b1);
    check("resume_q", 64'(q8), 64'hA5);
    check("resume_vld", 64'(vld8), 64'h1);

    // Asynchronous reset pulse between edges, then a discarded pending capture.
    @(negedge clk);
    sel    = 3'd6;
    in_vld = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("async_rst_q", 64'(q8), 64'h0);
    check("async_rst_vld", 64'(vld8), 64'h0);
    check("async_rst_out", 64'(out8), 64'hA6);
    #1 rst = 1'b0;
    in_vld = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_q", 64'(q8), 64'h0);
    check("post_rst_vld", 64'(vld8), 64'h0);
    step_capture(3'd7, 1'b1);
    check("first_cap_q", 64'(q8), 64'hA7);
    check("first_cap_vld", 64'(vld8), 64'h1);

    // Random vectors against the reference model, all three widths.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      in1 = 8'($urandom);
      in8 = {$urandom, $urandom};
      for (int w = 0; w < 8; w++) in32[w*32 +: 32] = $urandom;
      sel    = 3'($urandom_range(0, 7));
      in_vld = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_out1", 64'(out1), lane_of({248'b0, in1}, 1, int'(sel)));
      check("rnd_out8", 64'(out8), lane_of({192'b0, in8}, 8, int'(sel)));
      check("rnd_out32", 64'(out32), lane_of(in32, 32, int'(sel)));
      @(posedge clk);
      #1;
      check("rnd_q1", 64'(q1), m_q1);
      check("rnd_q8", 64'(q8), m_q8);
      check("rnd_q32", 64'(q32), m_q32);
      check("rnd_vld1", 64'(vld1), 64'(m_vld));
      check("rnd_vld32", 64'(vld32), 64'(m_vld));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_8to1.md
# mux_8to1

Eight-way selector: routes one of eight input lanes to the output under a 3-bit select, built as a three-level tree of seven 2:1 mux cells. It provides a combinational result plus a registered copy with a valid flag, for use in datapaths that need either zero-latency or one-cycle-pipelined selection. It sits in the basic-cells layer and is instantiated directly by datapath blocks.

## Interface

- DATA_W, default 1: width of each input lane and of the outputs; legal range 1–64.
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  reset; asynchronous, active-high; clears the registered path only.
- in  input  8*DATA_W  packed lanes; lane k occupies in[k*DATA_W +: DATA_W], k = 0..7.
- sel  input  3  lane index, binary, 0..7.
- in_vld  input  1  qualifies in/sel for the registered path.
- out  output  DATA_W  combinational selected lane: out = lane[sel].
- out_q  output  DATA_W  registered selected lane.
- out_vld  output  1  registered in_vld; marks out_q as valid.

## Operation

- Structure: a 2:1 cell with inputs a, b and select s gives s ? b : a.
  - Level 1: four cells on lane pairs (0,1), (2,3), (4,5), (6,7), selected by sel[0].
  - Level 2: two cells selected by sel[1].
  - Level 3: one cell selected by sel[2].
  - Net function: out = lane[sel]; sel = 0 picks lane 0 (LSB lane), sel = 7 picks lane 7.
- Combinational path (out): pure function of in and sel; no dependence on clk, rst or in_vld.
- Registered path:
  - On each rising clk with rst low: out_vld <= in_vld.
  - If in_vld = 1: out_q <= lane[sel].
  - If in_vld = 0: out_q holds its previous value.
- X/Z on sel: no requirement on the value of out. The design must not latch.
- No internal state beyond the out_q and out_vld flops.

## Timing

- out: zero-cycle latency, combinational from in/sel, three 2:1 cell delays deep.
- out_q / out_vld: one-cycle latency from the sampling edge.
- Throughput: one selection per cycle, no stall or back-pressure.
- Reset:
  - rst asserted forces out_q = 0 and out_vld = 0 immediately, regardless of clk.
  - While rst is high, clk edges are ignored.
  - The first capture is on the first rising clk after rst deasserts.
- Reset mid-stream: any pending capture is discarded, and out_vld reads 0 until in_vld is sampled high after release.
- out stays live during reset; it tracks in/sel.

## Test plan

- DATA_W = 1, in = 8'b10101010, sweep sel 0..7 with a 10-time-unit hold each -> out = 0,1,0,1,0,1,0,1.
- DATA_W = 1, in = 8'b11110000, sweep sel 0..7 -> out = 0,0,0,0,1,1,1,1.
- DATA_W = 8, lane k = 8'hA0+k, in_vld = 1, sel stepped 0..7 once per clock -> out_q = 8'hA0..8'hA7, each one cycle after its sel, with out_vld = 1.
- Registered path with in_vld = 0 for two cycles mid-sweep -> out_q holds its last value and out_vld = 0 for those cycles, resuming one cycle after in_vld returns high.
- rst pulsed between clock edges while out_q = 8'hA5, out_vld = 1 -> both clear to 0 immediately, before the next edge; out still equals lane[sel] throughout.
- Random in/sel, 1000 vectors, DATA_W in {1, 8, 32} -> out matches the reference model lane[sel] every vector; out_q matches the model's value one cycle later.
